dram_sync_fifo: RTL and testbench

Parametrised synchronous FIFO built on a distributed-RAM array with a registered read stage. It is the next-generation replacement for bare distributed-RAM-plus-output-register storage in the host datapath. Compared with that storage it adds:
- valid/ready handshakes on both sides;
- pointer management for non-power-of-two depths;
- occupancy and almost-full flags;
- a synchronous flush.
It is used for credit/tag buffering and small data queues between TL/DL stages.

---
 rtl/dram_sync_fifo_pkg.sv | 8 +
 rtl/dram_sdp_array.sv | 27 ++
 rtl/dram_sync_fifo.sv | 116 +++++++++++
 tb/tb_dram_sync_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_sync_fifo_pkg.sv
// Shared defaults for the distributed-RAM sync FIFO.
// Imported by the FIFO top.
package dram_sync_fifo_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 34;

endpackage

// File: rtl/dram_sdp_array.sv
// Simple-dual-port distributed RAM.
// Synchronous write, asynchronous read.
module dram_sdp_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "distributed" *)
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dram_sync_fifo.sv
// Sync FIFO on distributed RAM with a prefetching output register.
// count includes the output register; depth need not be 2^n.
module dram_sync_fifo
  import dram_sync_fifo_pkg::*;
#(
  parameter  int WIDTH        = DEF_WIDTH,
  parameter  int DEPTH        = DEF_DEPTH,
  parameter  int AFULL_THRESH = DEPTH - 4,
  localparam int ADDRWIDTH    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [ADDRWIDTH:0]   count,
  output logic                 almost_full,
  output logic                 empty
);

  localparam logic [ADDRWIDTH:0] CNT_DEPTH =
    (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] CNT_AF =
    (ADDRWIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDRWIDTH-1:0] PTR_LAST =
    ADDRWIDTH'(DEPTH - 1);

  function automatic logic [ADDRWIDTH-1:0] ptr_inc(
    input logic [ADDRWIDTH-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [ADDRWIDTH-1:0] wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [ADDRWIDTH:0]   ram_cnt;
  logic [ADDRWIDTH:0]   count_next;
  logic [WIDTH-1:0]     ram_rdata;
  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 clr;
  logic                 ram_we;

  assign clr      = reset | flush;
  assign wr_ready = (count != CNT_DEPTH);
  assign empty    = (count == '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign ram_cnt  = count - {{ADDRWIDTH{1'b0}}, rd_valid};
  assign load     = (ram_cnt != '0) & (~rd_valid | pop);
  assign ram_we   = push & ~clr;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  dram_sdp_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDRWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      // Prefetch keeps the output register full whenever RAM has data.
      if (load) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        rd_data  <= ram_rdata;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      count       <= count_next;
      almost_full <= (count_next >= CNT_AF);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!pop || rd_valid);
      assert (count <= CNT_DEPTH);
      assert ({1'b0, wr_ptr} < CNT_DEPTH);
      assert ({1'b0, rd_ptr} < CNT_DEPTH);
    end
  end
`endif

endmodule

// File: tb/tb_dram_sync_fifo.sv
// Directed bench for dram_sync_fifo.
// DEPTH=34, AFULL_THRESH=30.
module tb_dram_sync_fifo;

  localparam int W  = 64;
  localparam int D  = 34;
  localparam int AF = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [6:0]    count;
  logic          almost_full;
  logic          empty;

  int tests = 0;
  int fails = 0;
  int e;
  logic [W-1:0] held;

  always #5 clk = ~clk;

  dram_sync_fifo #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .empty       (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_wrr", 64'(wr_ready), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_rdd", rd_data, 64'd0);

    // single push latency and hold
    wr_valid = 1'b1;
    wr_data  = 64'hA5;
    tick();
    wr_valid = 1'b0;
    chk("lat_rdv0", 64'(rd_valid), 64'd0);
    chk("lat_cnt0", 64'(count), 64'd1);
    tick();
    chk("lat_rdv1", 64'(rd_valid), 64'd1);
    chk("lat_rdd1", rd_data, 64'hA5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rdd", rd_data, 64'hA5);
    end
    chk("hold_cnt", 64'(count), 64'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pop1_rdv", 64'(rd_valid), 64'd0);
    chk("pop1_empty", 64'(empty), 64'd1);

    // fill to full
    for (int i = 0; i < D; i++) begin
      wr_valid = 1'b1;
      wr_data  = 64'(i);
      tick();
    end
    chk("full_cnt", 64'(count), 64'd34);
    chk("full_wrr", 64'(wr_ready), 64'd0);
    chk("full_af", 64'(almost_full), 64'd1);
    chk("full_head", rd_data, 64'd0);
    wr_data = 64'hFF;
    tick();
    wr_valid = 1'b0;
    chk("ovf_cnt", 64'(count), 64'd34);
    held = rd_data;
    chk("ovf_head", held, 64'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("drain_rdv", 64'(rd_valid), 64'd1);
      chk("drain_rdd", rd_data, 64'(i));
      tick();
    end
    rd_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_rdv_end", 64'(rd_valid), 64'd0);

    // streaming through pointer wrap
    e = 0;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_data = 64'(k);
      if (rd_valid) begin
        chk("stream_rdd", rd_data, 64'(e));
        e++;
      end
      tick();
      if (k >= 1) chk("stream_cnt", 64'(count), 64'd2);
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rd_valid) begin
        chk("stream_tail", rd_data, 64'(e));
        e++;
      end
      tick();
    end
    rd_ready = 1'b0;
    chk("stream_total", 64'(e), 64'd200);
    chk("stream_empty", 64'(empty), 64'd1);

    // almost_full threshold
    for (int i = 0; i < AF - 1; i++) begin
      wr_valid = 1'b1;
      wr_data  = 64'(i + 100);
      tick();
    end
    wr_valid = 1'b0;
    chk("af29_cnt", 64'(count), 64'd29);
    chk("af29", 64'(almost_full), 64'd0);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("af30_cnt", 64'(count), 64'd30);
    chk("af30", 64'(almost_full), 64'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("afpop_cnt", 64'(count), 64'd29);
    chk("afpop", 64'(almost_full), 64'd0);

    // flush with push and pop
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl0_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 64'(i + 200);
      tick();
    end
    chk("fl5_cnt", 64'(count), 64'd5);
    chk("fl5_rdv", 64'(rd_valid), 64'd1);
    flush    = 1'b1;
    wr_data  = 64'h99;
    rd_ready = 1'b1;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_rdv", 64'(rd_valid), 64'd0);
    chk("fl_rdd", rd_data, 64'd0);
    chk("fl_af", 64'(almost_full), 64'd0);
    wr_valid = 1'b1;
    wr_data  = 64'h3C;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("fl_re_rdv", 64'(rd_valid), 64'd1);
    chk("fl_re_rdd", rd_data, 64'h3C);
    chk("fl_re_cnt", 64'(count), 64'd1);

    // reset while full with write attempt
    for (int i = 0; i < D - 1; i++) begin
      wr_valid = 1'b1;
      wr_data  = 64'(i + 300);
      tick();
    end
    chk("rf_cnt", 64'(count), 64'd34);
    chk("rf_wrr", 64'(wr_ready), 64'd0);
    reset   = 1'b1;
    wr_data = 64'hDEAD;
    tick();
    reset    = 1'b0;
    wr_valid = 1'b0;
    chk("rf_cnt0", 64'(count), 64'd0);
    chk("rf_wrr1", 64'(wr_ready), 64'd1);
    chk("rf_empty", 64'(empty), 64'd1);
    tick();
    tick();
    chk("rf_still", 64'(count), 64'd0);
    chk("rf_rdv", 64'(rd_valid), 64'd0);
    wr_valid = 1'b1;
    wr_data  = 64'h77;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("rf_re_rdd", rd_data, 64'h77);
    chk("rf_re_cnt", 64'(count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
